fix_point_mul_seq: RTL



---
 rtl/fix_point_pkg.sv | 31 +++
 rtl/fix_point_mul_seq_if.sv | 31 +++
 rtl/fix_point_round_sat.sv | 51 +++++
 rtl/fix_point_mul_seq.sv | 134 +++++++++++++
 4 files changed

// File: rtl/fix_point_pkg.sv
// ============================================================================
// fix_point_pkg : shared FSM state type and width helpers for fixed-point units
// Rev 1.0
// ============================================================================
`default_nettype none

package fix_point_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int calc_wi(input int w_integer_i, input int w_fractional_i);
        return w_integer_i + w_fractional_i;
    endfunction

    function automatic int calc_wo(input int w_integer_o, input int w_fractional_o);
        return w_integer_o + w_fractional_o;
    endfunction

    // Right shift that takes a full-precision product back to the output LSB.
    function automatic int calc_sh(input int w_fractional_i, input int w_fractional_o);
        return 2 * w_fractional_i - w_fractional_o;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fix_point_mul_seq_if.sv
// ============================================================================
// fix_point_mul_seq_if : operand/result valid-ready bus of the fixed-point multiplier
// Rev 1.0
// ============================================================================
`default_nettype none

interface fix_point_mul_seq_if #(
    parameter int W_IN  = 32,
    parameter int W_OUT = 32
) ();
    logic              in_valid;
    logic              in_ready;
    logic [W_IN-1:0]   a;
    logic [W_IN-1:0]   b;
    logic              out_valid;
    logic              out_ready;
    logic [W_OUT-1:0]  c;
    logic              ovf;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, c, ovf
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, c, ovf
    );
endinterface

`default_nettype wire

// File: rtl/fix_point_round_sat.sv
// ============================================================================
// fix_point_round_sat : round-half-away-from-zero and saturate a sign/magnitude value
// Rev 1.0
// ============================================================================
`default_nettype none

module fix_point_round_sat #(
    parameter int W_MAG = 64,
    parameter int W_OUT = 32,
    parameter int SH    = 29
) (
    input  wire logic [W_MAG-1:0] mag,
    input  wire logic             sign,
    output logic      [W_OUT-1:0] c,
    output logic                  ovf
);
    localparam logic [W_MAG:0] C_ONE     = {{W_MAG{1'b0}}, 1'b1};
    localparam logic [W_MAG:0] C_NEG_LIM = C_ONE << (W_OUT - 1);
    localparam logic [W_MAG:0] C_POS_LIM = C_NEG_LIM - C_ONE;

    logic [W_MAG:0] w_bias;
    logic [W_MAG:0] w_mr;

    generate
        if (SH > 0) begin : g_bias
            assign w_bias = C_ONE << (SH - 1);
        end else begin : g_no_bias
            assign w_bias = '0;
        end
    endgenerate

    // Extra headroom bit keeps the rounding add from wrapping.
    assign w_mr = ({1'b0, mag} + w_bias) >> SH;

    always_comb begin
        c   = '0;
        ovf = 1'b0;
        if (!sign && (w_mr > C_POS_LIM)) begin
            c   = {1'b0, {(W_OUT-1){1'b1}}};
            ovf = 1'b1;
        end else if (sign && (w_mr > C_NEG_LIM)) begin
            c   = {1'b1, {(W_OUT-1){1'b0}}};
            ovf = 1'b1;
        end else begin
            c = sign ? (~w_mr[W_OUT-1:0] + {{(W_OUT-1){1'b0}}, 1'b1}) : w_mr[W_OUT-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/fix_point_mul_seq.sv
// ============================================================================
// fix_point_mul_seq : sequential signed shift-add fixed-point multiplier, Q16.16 -> Q29.3
// Rev 1.0
// ============================================================================
`default_nettype none

module fix_point_mul_seq
    import fix_point_pkg::*;
#(
    parameter int W_INTEGER_I    = 16,
    parameter int W_FRACTIONAL_I = 16,
    parameter int W_INTEGER_O    = 29,
    parameter int W_FRACTIONAL_O = 3
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    fix_point_mul_seq_if.slave bus
);
    localparam int WI = calc_wi(W_INTEGER_I, W_FRACTIONAL_I);
    localparam int WO = calc_wo(W_INTEGER_O, W_FRACTIONAL_O);
    localparam int SH = calc_sh(W_FRACTIONAL_I, W_FRACTIONAL_O);
    localparam int CW = $clog2(WI);

    generate
        if (2 * W_FRACTIONAL_I < W_FRACTIONAL_O) begin : g_param_check
            $error("fix_point_mul_seq: 2*W_FRACTIONAL_I must be >= W_FRACTIONAL_O");
        end
    endgenerate

    state_t            state_q,  state_d;
    logic [2*WI-1:0]   mcand_q,  mcand_d;
    logic [WI-1:0]     mplier_q, mplier_d;
    logic [2*WI-1:0]   acc_q,    acc_d;
    logic [CW-1:0]     cnt_q,    cnt_d;
    logic              sign_q,   sign_d;
    logic [WO-1:0]     c_q,      c_d;
    logic              ovf_q,    ovf_d;

    logic [WI-1:0]     w_abs_a;
    logic [WI-1:0]     w_abs_b;
    logic [WO-1:0]     w_c;
    logic              w_ovf;

    // Unsigned WI-bit magnitude, so the most negative operand maps to 2^(WI-1).
    assign w_abs_a = bus.a[WI-1] ? (~bus.a + WI'(1)) : bus.a;
    assign w_abs_b = bus.b[WI-1] ? (~bus.b + WI'(1)) : bus.b;

    fix_point_round_sat #(
        .W_MAG (2*WI),
        .W_OUT (WO),
        .SH    (SH)
    ) u_round_sat (
        .mag  (acc_q),
        .sign (sign_q),
        .c    (w_c),
        .ovf  (w_ovf)
    );

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        c_d      = c_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    mcand_d  = {{WI{1'b0}}, w_abs_a};
                    mplier_d = w_abs_b;
                    acc_d    = '0;
                    cnt_d    = CW'(WI - 1);
                    sign_d   = bus.a[WI-1] ^ bus.b[WI-1];
                    state_d  = MUL;
                end
            end
            MUL: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FIX: begin
                c_d     = w_c;
                ovf_d   = w_ovf;
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            c_q      <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            c_q      <= c_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.c         = c_q;
    assign bus.ovf       = ovf_q;

endmodule

`default_nettype wire
